ttt_board_ctrl: RTL and testbench

//  Downstream consumer of the cursor generator's 10-bit x/y position on a 640x480 screen.

---
 rtl/ttt_board_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_ttt_board_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ttt_board_ctrl.sv
// Tic-tac-toe controller: maps the cursor to a 3x3 grid, debounces the buttons,
// records alternating X/O marks and reports win/draw status.
module ttt_board_ctrl #(
  parameter int BOARD_X0        = 170,
  parameter int BOARD_Y0        = 90,
  parameter int CELL            = 100,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] x_pos,
  input  logic [9:0] y_pos,
  input  logic       select_btn,
  input  logic       new_game_btn,
  output logic [3:0] cell_idx,
  output logic       cell_valid,
  output logic [8:0] board_x,
  output logic [8:0] board_o,
  output logic       turn_o,
  output logic [1:0] game_state,
  output logic [7:0] win_line,
  output logic       move_pulse
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] GS_PLAY = 2'd0;
  localparam logic [1:0] GS_XWIN = 2'd1;
  localparam logic [1:0] GS_OWIN = 2'd2;
  localparam logic [1:0] GS_DRAW = 2'd3;

  typedef enum logic [1:0] {PLAY, CHECK, OVER} stateT;

  // Returns 0..2 for the band the coordinate falls in, 3 when off-grid.
  function automatic logic [1:0] axisIdx(input logic [9:0] p, input int base);
    logic [10:0] v;
    v = {1'b0, p};
    if (v < 11'(base))                 axisIdx = 2'd3;
    else if (v < 11'(base + CELL))     axisIdx = 2'd0;
    else if (v < 11'(base + 2 * CELL)) axisIdx = 2'd1;
    else if (v < 11'(base + 3 * CELL)) axisIdx = 2'd2;
    else                               axisIdx = 2'd3;
  endfunction

  logic [1:0] col, row;
  logic [3:0] cellIdxR;
  logic       cellValidR;

  assign col = axisIdx(x_pos, BOARD_X0);
  assign row = axisIdx(y_pos, BOARD_Y0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cellIdxR   <= 4'd15;
      cellValidR <= 1'b0;
    end else if (col == 2'd3 || row == 2'd3) begin
      cellIdxR   <= 4'd15;
      cellValidR <= 1'b0;
    end else begin
      cellIdxR   <= 4'(row) * 4'd3 + 4'(col);
      cellValidR <= 1'b1;
    end
  end

  // Button conditioning; index 0 = select, 1 = new game.
  logic [1:0]    rawBtn, sync1, sync2, accepted, btnPulse;
  logic [CW-1:0] cnt [2];

  assign rawBtn = {new_game_btn, select_btn};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= '0;
      sync2    <= '0;
      accepted <= '0;
      btnPulse <= '0;
      for (int i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      sync1 <= rawBtn;
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        btnPulse[i] <= 1'b0;
        if (sync2[i] == accepted[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          cnt[i]      <= '0;
          accepted[i] <= sync2[i];
          btnPulse[i] <= sync2[i];
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  logic selP, ngP;
  assign selP = btnPulse[0];
  assign ngP  = btnPulse[1];

  stateT      state, stateNext;
  logic [8:0] boardX, boardO, boardXNext, boardONext;
  logic       turnO, turnONext, movePulse, movePulseNext;
  logic [1:0] gameState, gameStateNext;
  logic [7:0] winLine, winLineNext, hits;
  logic [8:0] mover, cellMask, filled;

  assign mover    = turnO ? boardO : boardX;
  assign filled   = boardX | boardO;
  assign cellMask = 9'd1 << cellIdxR;

  assign hits[0] = mover[0] & mover[1] & mover[2];
  assign hits[1] = mover[3] & mover[4] & mover[5];
  assign hits[2] = mover[6] & mover[7] & mover[8];
  assign hits[3] = mover[0] & mover[3] & mover[6];
  assign hits[4] = mover[1] & mover[4] & mover[7];
  assign hits[5] = mover[2] & mover[5] & mover[8];
  assign hits[6] = mover[0] & mover[4] & mover[8];
  assign hits[7] = mover[2] & mover[4] & mover[6];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= PLAY;
      boardX    <= '0;
      boardO    <= '0;
      turnO     <= 1'b0;
      gameState <= GS_PLAY;
      winLine   <= '0;
      movePulse <= 1'b0;
    end else begin
      state     <= stateNext;
      boardX    <= boardXNext;
      boardO    <= boardONext;
      turnO     <= turnONext;
      gameState <= gameStateNext;
      winLine   <= winLineNext;
      movePulse <= movePulseNext;
    end
  end

  always_comb begin
    stateNext     = state;
    boardXNext    = boardX;
    boardONext    = boardO;
    turnONext     = turnO;
    gameStateNext = gameState;
    winLineNext   = winLine;
    movePulseNext = 1'b0;
    if (ngP) begin
      // New game overrides any select arriving in the same cycle.
      stateNext     = PLAY;
      boardXNext    = '0;
      boardONext    = '0;
      turnONext     = 1'b0;
      gameStateNext = GS_PLAY;
      winLineNext   = '0;
    end else begin
      case (state)
        PLAY: begin
          if (selP && cellValidR && ((filled & cellMask) == 9'd0)) begin
            if (turnO) boardONext = boardO | cellMask;
            else       boardXNext = boardX | cellMask;
            movePulseNext = 1'b1;
            stateNext     = CHECK;
          end
        end
        CHECK: begin
          if (hits != 8'd0) begin
            gameStateNext = turnO ? GS_OWIN : GS_XWIN;
            winLineNext   = hits;
            stateNext     = OVER;
          end else if (&filled) begin
            gameStateNext = GS_DRAW;
            stateNext     = OVER;
          end else begin
            turnONext = ~turnO;
            stateNext = PLAY;
          end
        end
        OVER:    stateNext = OVER;
        default: stateNext = PLAY;
      endcase
    end
  end

  assign cell_idx   = cellIdxR;
  assign cell_valid = cellValidR;
  assign board_x    = boardX;
  assign board_o    = boardO;
  assign turn_o     = turnO;
  assign game_state = gameState;
  assign win_line   = winLine;
  assign move_pulse = movePulse;

endmodule

// File: tb/tb_ttt_board_ctrl.sv
// Directed bench for ttt_board_ctrl with a short debounce window.
module tb_ttt_board_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] x_pos, y_pos;
  logic       select_btn, new_game_btn;
  logic [3:0] cell_idx;
  logic       cell_valid;
  logic [8:0] board_x, board_o;
  logic       turn_o;
  logic [1:0] game_state;
  logic [7:0] win_line;
  logic       move_pulse;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int p0;

  int m4 [5] = '{0, 3, 1, 4, 2};
  int m5 [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};

  ttt_board_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .x_pos        (x_pos),
    .y_pos        (y_pos),
    .select_btn   (select_btn),
    .new_game_btn (new_game_btn),
    .cell_idx     (cell_idx),
    .cell_valid   (cell_valid),
    .board_x      (board_x),
    .board_o      (board_o),
    .turn_o       (turn_o),
    .game_state   (game_state),
    .win_line     (win_line),
    .move_pulse   (move_pulse)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (move_pulse) pulses++;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic setXY(input int x, input int y);
    x_pos = 10'(x);
    y_pos = 10'(y);
    cyc(2);
  endtask

  task automatic setCell(input int c);
    setXY(170 + 100 * (c % 3) + 50, 90 + 100 * (c / 3) + 50);
  endtask

  task automatic pressSel();
    select_btn = 1'b1;
    cyc(10);
    select_btn = 1'b0;
    cyc(10);
  endtask

  task automatic pressNg();
    new_game_btn = 1'b1;
    cyc(10);
    new_game_btn = 1'b0;
    cyc(10);
  endtask

  task automatic move(input int c);
    setCell(c);
    pressSel();
  endtask

  initial begin
    rst_n = 1'b0;
    select_btn = 1'b0;
    new_game_btn = 1'b0;
    x_pos = 10'd0;
    y_pos = 10'd0;
    cyc(3);
    check("rst_cell_idx_in_reset", 32'(cell_idx), 32'd15);
    rst_n = 1'b1;
    cyc(2);
    check("rst_cell_idx", 32'(cell_idx), 32'd15);
    check("rst_cell_valid", 32'(cell_valid), 32'd0);
    check("rst_board_x", 32'(board_x), 32'd0);
    check("rst_board_o", 32'(board_o), 32'd0);
    check("rst_turn", 32'(turn_o), 32'd0);
    check("rst_state", 32'(game_state), 32'd0);
    check("rst_win_line", 32'(win_line), 32'd0);
    check("rst_move_pulse", 32'(move_pulse), 32'd0);

    // Cell mapping, including both grid edges
    setXY(320, 240); check("map_center", 32'(cell_idx), 32'd4);
    check("map_center_valid", 32'(cell_valid), 32'd1);
    setXY(170, 90);  check("map_origin", 32'(cell_idx), 32'd0);
    setXY(469, 389); check("map_last_px", 32'(cell_idx), 32'd8);
    setXY(470, 240); check("map_right_edge", 32'(cell_idx), 32'd15);
    check("map_right_edge_valid", 32'(cell_valid), 32'd0);
    setXY(169, 90);  check("map_left_edge", 32'(cell_idx), 32'd15);
    setXY(320, 390); check("map_bottom_edge", 32'(cell_idx), 32'd15);
    setXY(271, 289); check("map_cell4_corner", 32'(cell_idx), 32'd4);

    // Bouncing select must yield exactly one move
    setCell(4);
    p0 = pulses;
    for (int i = 0; i < 10; i++) begin
      select_btn = ~select_btn;
      cyc(2);
    end
    check("bounce_no_pulse", 32'(pulses - p0), 32'd0);
    select_btn = 1'b1;
    cyc(10);
    select_btn = 1'b0;
    cyc(10);
    check("bounce_one_pulse", 32'(pulses - p0), 32'd1);
    check("bounce_board_x", 32'(board_x), 32'h010);
    check("bounce_turn", 32'(turn_o), 32'd1);

    pressNg();
    check("ng_board_x", 32'(board_x), 32'd0);
    check("ng_turn", 32'(turn_o), 32'd0);

    // X wins on the top row
    for (int i = 0; i < 5; i++) move(m4[i]);
    check("xwin_board_x", 32'(board_x), 32'h007);
    check("xwin_board_o", 32'(board_o), 32'h018);
    check("xwin_state", 32'(game_state), 32'd1);
    check("xwin_line", 32'(win_line), 32'h01);
    p0 = pulses;
    move(5);
    check("over_no_pulse", 32'(pulses - p0), 32'd0);
    check("over_board_o", 32'(board_o), 32'h018);
    check("over_state", 32'(game_state), 32'd1);

    // Full board with no line: draw
    pressNg();
    check("ng2_state", 32'(game_state), 32'd0);
    check("ng2_win_line", 32'(win_line), 32'd0);
    p0 = pulses;
    for (int i = 0; i < 9; i++) move(m5[i]);
    check("draw_pulses", 32'(pulses - p0), 32'd9);
    check("draw_board_x", 32'(board_x), 32'h18D);
    check("draw_board_o", 32'(board_o), 32'h072);
    check("draw_state", 32'(game_state), 32'd3);
    check("draw_win_line", 32'(win_line), 32'd0);

    // Occupied cell, then new game racing a select
    pressNg();
    move(4);
    p0 = pulses;
    move(4);
    check("occ_no_pulse", 32'(pulses - p0), 32'd0);
    check("occ_board_x", 32'(board_x), 32'h010);
    check("occ_board_o", 32'(board_o), 32'h000);
    check("occ_turn", 32'(turn_o), 32'd1);
    setCell(0);
    p0 = pulses;
    select_btn = 1'b1;
    new_game_btn = 1'b1;
    cyc(10);
    select_btn = 1'b0;
    new_game_btn = 1'b0;
    cyc(10);
    check("race_no_pulse", 32'(pulses - p0), 32'd0);
    check("race_board_x", 32'(board_x), 32'd0);
    check("race_board_o", 32'(board_o), 32'd0);
    check("race_turn", 32'(turn_o), 32'd0);
    check("race_state", 32'(game_state), 32'd0);

    // Async reset while the FSM is in CHECK
    setCell(2);
    select_btn = 1'b1;
    for (int i = 0; i < 20 && !move_pulse; i++) @(negedge clk);
    check("midcheck_pulse_seen", 32'(move_pulse), 32'd1);
    check("midcheck_board_x", 32'(board_x), 32'h004);
    rst_n = 1'b0;
    #1;
    check("midrst_board_x", 32'(board_x), 32'd0);
    check("midrst_move_pulse", 32'(move_pulse), 32'd0);
    check("midrst_cell_idx", 32'(cell_idx), 32'd15);
    check("midrst_cell_valid", 32'(cell_valid), 32'd0);
    select_btn = 1'b0;
    cyc(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
